// File: rtl/text_char_fetch.sv
// Text-mode character fetch: maps pixel position to a VRAM word, reads the cell,
// applies cursor blink and delays position/sync so everything reaches the colour mapper aligned.
module text_char_fetch #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int READ_LATENCY = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        vde,
  output logic [10:0] vram_addr,
  output logic        vram_en,
  input  logic [31:0] vram_rdata,
  input  logic        cursor_en,
  input  logic [11:0] cursor_pos,
  output logic [15:0] char_o,
  output logic        is_inverted,
  output logic [9:0]  DrawX_o,
  output logic [9:0]  DrawY_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        vde_o,
  output logic        frame_tick
);

  localparam int              L       = 1 + READ_LATENCY;
  localparam logic [9:0]      VIS_W   = 10'(COLS * 8);
  localparam logic [9:0]      VIS_H   = 10'(ROWS * 16);
  localparam logic [11:0]     CELLS   = 12'(COLS * ROWS);
  localparam int              CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic       idx0;
    logic       hit;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
  } side_t;

  // Syncs are active-low, so their idle (reset) level is 1.
  localparam side_t SIDE_RST = side_t'({1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0});

  typedef enum logic {BLINK_ON, BLINK_OFF} blink_state_t;

  blink_state_t      blink_state_reg, blink_state_next;
  logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic [11:0]       cursor_lat_reg;
  logic              vsync_prev_reg;
  logic              blink_on;

  logic [6:0]  col;
  logic [5:0]  row;
  logic [11:0] idx;
  logic        visible;
  logic        cursor_hit;
  side_t       side_in;
  side_t       side_out;
  logic [15:0] char_sel;

  assign col     = DrawX[9:3];
  assign row     = DrawY[9:4];
  assign idx     = 12'(int'(row) * COLS + int'(col));
  assign visible = (DrawX < VIS_W) && (DrawY < VIS_H);

  // Cursor compares against the frame-latched position so a mid-frame move cannot tear.
  assign cursor_hit = cursor_en && visible && (cursor_lat_reg < CELLS) && (idx == cursor_lat_reg);

  assign side_in = side_t'({idx[0], cursor_hit, DrawX, DrawY, hsync, vsync, vde});

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vram_addr <= '0;
      vram_en   <= 1'b0;
    end else begin
      vram_en <= visible;
      if (visible) begin
        vram_addr <= idx[11:1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_side
      side_t stage_reg;
      side_t stage_d;
      if (gi == 0) begin : g_src
        assign stage_d = side_in;
      end else begin : g_src
        assign stage_d = g_side[gi-1].stage_reg;
      end
      always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
          stage_reg <= SIDE_RST;
        end else begin
          stage_reg <= stage_d;
        end
      end
    end
  endgenerate

  assign side_out = g_side[L-1].stage_reg;
  assign char_sel = side_out.idx0 ? vram_rdata[31:16] : vram_rdata[15:0];

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      char_o      <= '0;
      is_inverted <= 1'b0;
      DrawX_o     <= '0;
      DrawY_o     <= '0;
      hsync_o     <= 1'b1;
      vsync_o     <= 1'b1;
      vde_o       <= 1'b0;
    end else begin
      if (side_out.de) begin
        char_o      <= char_sel;
        is_inverted <= char_sel[15] ^ (side_out.hit & blink_on);
      end else begin
        char_o      <= '0;
        is_inverted <= 1'b0;
      end
      DrawX_o <= side_out.x;
      DrawY_o <= side_out.y;
      hsync_o <= side_out.hs;
      vsync_o <= side_out.vs;
      vde_o   <= side_out.de;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vsync_prev_reg  <= 1'b1;
      frame_tick      <= 1'b0;
      cursor_lat_reg  <= '0;
      frame_cnt_reg   <= '0;
      blink_state_reg <= BLINK_ON;
    end else begin
      vsync_prev_reg  <= vsync;
      frame_tick      <= vsync_prev_reg & ~vsync;
      frame_cnt_reg   <= frame_cnt_next;
      blink_state_reg <= blink_state_next;
      if (frame_tick) begin
        cursor_lat_reg <= cursor_pos;
      end
    end
  end

  always_comb begin
    blink_state_next = blink_state_reg;
    frame_cnt_next   = frame_cnt_reg;
    if (frame_tick) begin
      if (frame_cnt_reg == CNT_MAX) begin
        frame_cnt_next   = '0;
        blink_state_next = (blink_state_reg == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
  end

  assign blink_on = (blink_state_reg == BLINK_ON);

endmodule
